zipmmu_tlbload: RTL



---
 rtl/zipmmu_tlbload.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/zipmmu_tlbload.sv
// Hardware TLB-miss loader: fetches a two-word PTE over pipelined Wishbone and writes it into the
// MMU control port at a round-robin slot. Define ZIPMMU_TLBLOAD_CTXCHK_EN to also check the PTE context field.
module zipmmu_tlbload #(
    parameter int AW      = 30,
    parameter int LGTBL   = 6,
    parameter int LGPGSZB = 12,
    parameter int LGPT    = 10,
    localparam int VPW    = 32 - LGPGSZB
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_req,
    input  logic [VPW-1:0]   i_vpage,
    input  logic [7:0]       i_context,
    input  logic [AW-1:0]    i_pt_base,
    output logic             o_busy,
    output logic             o_done,
    output logic [1:0]       o_fault,
    output logic             o_mem_cyc,
    output logic             o_mem_stb,
    output logic [AW-1:0]    o_mem_addr,
    input  logic             i_mem_stall,
    input  logic             i_mem_ack,
    input  logic             i_mem_err,
    input  logic [31:0]      i_mem_data,
    output logic             o_ctl_cyc_stb,
    output logic             o_ctl_we,
    output logic [LGTBL+1:0] o_ctl_addr,
    output logic [31:0]      o_ctl_data,
    input  logic             i_ctl_stall,
    input  logic             i_ctl_ack
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_RDWAIT,
        S_CHECK,
        S_WRV,
        S_WRP,
        S_DONE
    } state_t;

    localparam logic [1:0] F_OK  = 2'b00;
    localparam logic [1:0] F_BUS = 2'b01;
    localparam logic [1:0] F_TAG = 2'b10;
`ifdef ZIPMMU_TLBLOAD_CTXCHK_EN
    localparam logic [1:0] F_CTX = 2'b11;
`endif

    state_t           state_q, state_d;
    logic             beat_q, beat_d;
    logic             ack_cnt_q, ack_cnt_d;
    logic             ctl_sent_q, ctl_sent_d;
    logic [AW-1:0]    mem_addr_q, mem_addr_d;
    logic [31:0]      word0_q, word0_d;
    logic [31:0]      word1_q, word1_d;
    logic [VPW-1:0]   vpage_q, vpage_d;
    logic [LGTBL-1:0] idx_q, idx_d;
    logic [1:0]       fault_q, fault_d;
    logic [AW-1:0]    pte_addr;
    logic             ctl_strobe;
    logic             ctl_sel;

`ifdef ZIPMMU_TLBLOAD_CTXCHK_EN
    logic [7:0]       ctx_q, ctx_d;
`else
    logic             unused_ctx;
    assign unused_ctx = ^i_context;
`endif

    // Two PTE words per page, so the table index is scaled by two before adding the base.
    assign pte_addr = i_pt_base + AW'({i_vpage[LGPT-1:0], 1'b0});

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= S_IDLE;
            beat_q     <= 1'b0;
            ack_cnt_q  <= 1'b0;
            ctl_sent_q <= 1'b0;
            mem_addr_q <= '0;
            word0_q    <= '0;
            word1_q    <= '0;
            vpage_q    <= '0;
            idx_q      <= '0;
            fault_q    <= F_OK;
`ifdef ZIPMMU_TLBLOAD_CTXCHK_EN
            ctx_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            ack_cnt_q  <= ack_cnt_d;
            ctl_sent_q <= ctl_sent_d;
            mem_addr_q <= mem_addr_d;
            word0_q    <= word0_d;
            word1_q    <= word1_d;
            vpage_q    <= vpage_d;
            idx_q      <= idx_d;
            fault_q    <= fault_d;
`ifdef ZIPMMU_TLBLOAD_CTXCHK_EN
            ctx_q      <= ctx_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        ack_cnt_d  = ack_cnt_q;
        ctl_sent_d = ctl_sent_q;
        mem_addr_d = mem_addr_q;
        word0_d    = word0_q;
        word1_d    = word1_q;
        vpage_d    = vpage_q;
        idx_d      = idx_q;
        fault_d    = fault_q;
`ifdef ZIPMMU_TLBLOAD_CTXCHK_EN
        ctx_d      = ctx_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (i_req) begin
                    state_d    = S_RD;
                    vpage_d    = i_vpage;
                    mem_addr_d = pte_addr;
                    beat_d     = 1'b0;
                    ack_cnt_d  = 1'b0;
                    fault_d    = F_OK;
`ifdef ZIPMMU_TLBLOAD_CTXCHK_EN
                    ctx_d      = i_context;
`endif
                end
            end

            S_RD, S_RDWAIT: begin
                if (i_mem_err) begin
                    state_d = S_DONE;
                    fault_d = F_BUS;
                end else begin
                    if (i_mem_ack) begin
                        if (ack_cnt_q)
                            word1_d = i_mem_data;
                        else
                            word0_d = i_mem_data;
                        ack_cnt_d = 1'b1;
                    end
                    if (state_q == S_RD && !i_mem_stall) begin
                        if (beat_q) begin
                            state_d = S_RDWAIT;
                        end else begin
                            beat_d     = 1'b1;
                            mem_addr_d = mem_addr_q + AW'(1);
                        end
                    end
                    // Acks can overlap the second request beat, so the final ack decides the exit.
                    if (i_mem_ack && ack_cnt_q)
                        state_d = S_CHECK;
                end
            end

            S_CHECK: begin
                ctl_sent_d = 1'b0;
                if (word0_q[31:LGPGSZB] != vpage_q) begin
                    state_d = S_DONE;
                    fault_d = F_TAG;
                end
`ifdef ZIPMMU_TLBLOAD_CTXCHK_EN
                else if (word0_q[11:4] != ctx_q) begin
                    state_d = S_DONE;
                    fault_d = F_CTX;
                end
`endif
                else begin
                    state_d = S_WRV;
                end
            end

            S_WRV: begin
                if (!ctl_sent_q) begin
                    if (!i_ctl_stall)
                        ctl_sent_d = 1'b1;
                end else if (i_ctl_ack) begin
                    ctl_sent_d = 1'b0;
                    state_d    = S_WRP;
                end
            end

            S_WRP: begin
                if (!ctl_sent_q) begin
                    if (!i_ctl_stall)
                        ctl_sent_d = 1'b1;
                end else if (i_ctl_ack) begin
                    ctl_sent_d = 1'b0;
                    idx_d      = idx_q + LGTBL'(1);
                    state_d    = S_DONE;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control bus fields are zero except while a table write is being presented.
    assign ctl_strobe = (state_q == S_WRV || state_q == S_WRP) && !ctl_sent_q;
    assign ctl_sel    = (state_q == S_WRP);

    assign o_busy        = (state_q != S_IDLE) && (state_q != S_DONE);
    assign o_done        = (state_q == S_DONE);
    assign o_fault       = (state_q == S_DONE) ? fault_q : F_OK;
    assign o_mem_cyc     = (state_q == S_RD) || (state_q == S_RDWAIT);
    assign o_mem_stb     = (state_q == S_RD);
    assign o_mem_addr    = mem_addr_q;
    assign o_ctl_cyc_stb = ctl_strobe;
    assign o_ctl_we      = ctl_strobe;
    assign o_ctl_addr    = ctl_strobe ? {1'b1, idx_q, ctl_sel} : '0;
    assign o_ctl_data    = ctl_strobe ? (ctl_sel ? word1_q : word0_q) : '0;

endmodule
